// File: rtl/fp32_add_pipe_if.sv
// Operand/result bundle for the FP32 adder pipeline.
// The upstream stage drives operands; the adder drives the sum.
interface fp32_add_pipe_if;
    logic        valid_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic [31:0] sum_o;

    modport master (output valid_i, output a_i, output b_i, input valid_o, input sum_o);
    modport slave  (input valid_i, input a_i, input b_i, output valid_o, output sum_o);
endinterface

// File: rtl/fp32_add_pipe.sv
// Four-stage FP32 adder: unpack/compare, align, add/sub, normalize/pack.
// Flush-to-zero, truncation rounding, falling-edge clock, no stall path.
module fp32_add_pipe #(
    parameter int LATENCY  = 4,
    parameter int EXP_BIAS = 127
) (
    input  logic           clkn_i,
    input  logic           rst_i,
    fp32_add_pipe_if.slave bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    generate
        if (LATENCY != 4 || EXP_BIAS != 127) begin : g_bad_param
            $error("fp32_add_pipe: only LATENCY=4 and EXP_BIAS=127 are supported");
        end
    endgenerate

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + 5'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Stage 1 registers
    logic        v1_q, v1_d, byp1_q, byp1_d, sign1_q, sign1_d, sub1_q, sub1_d;
    logic [31:0] bypv1_q, bypv1_d;
    logic [7:0]  exp1_q, exp1_d, d1_q, d1_d;
    logic [23:0] sigb1_q, sigb1_d, sigs1_q, sigs1_d;
    // Stage 2 registers
    logic        v2_q, v2_d, byp2_q, byp2_d, sign2_q, sign2_d, sub2_q, sub2_d;
    logic [31:0] bypv2_q, bypv2_d;
    logic [7:0]  exp2_q, exp2_d;
    logic [23:0] sigb2_q, sigb2_d;
    logic [26:0] small2_q, small2_d;
    // Stage 3 registers
    logic        v3_q, v3_d, byp3_q, byp3_d, sign3_q, sign3_d;
    logic [31:0] bypv3_q, bypv3_d;
    logic [7:0]  exp3_q, exp3_d;
    logic [27:0] sum3_q, sum3_d;
    // Output registers
    logic        valid_q, valid_d;
    logic [31:0] sum_q, sum_d;

    logic [7:0]        a_exp_s, b_exp_s;
    logic              a_zero_s, b_zero_s, spec_s, a_big_s;
    logic [4:0]        lzc_s;
    logic [26:0]       norm_sh_s;
    logic [22:0]       frac_s;
    logic signed [9:0] exp_n_s;
    logic [31:0]       res_s;
    logic              unused_s;

    assign a_exp_s  = bus.a_i[30:23];
    assign b_exp_s  = bus.b_i[30:23];
    assign a_zero_s = (a_exp_s == 8'd0);
    assign b_zero_s = (b_exp_s == 8'd0);
    assign spec_s   = (a_exp_s == 8'hFF) || (b_exp_s == 8'hFF);
    assign a_big_s  = (bus.a_i[30:0] >= bus.b_i[30:0]);

    // Stage 1: classify operands, resolve zero/special results early, order by magnitude
    always_comb begin
        v1_d   = bus.valid_i;
        byp1_d = spec_s | a_zero_s | b_zero_s;
        sub1_d = bus.a_i[31] ^ bus.b_i[31];
        if (spec_s) begin
            bypv1_d = QNAN;
        end else if (a_zero_s && b_zero_s) begin
            bypv1_d = 32'h0000_0000;
        end else if (a_zero_s) begin
            bypv1_d = bus.b_i;
        end else if (b_zero_s) begin
            bypv1_d = bus.a_i;
        end else begin
            bypv1_d = 32'h0000_0000;
        end
        if (a_big_s) begin
            sign1_d = bus.a_i[31];
            exp1_d  = a_exp_s;
            sigb1_d = {1'b1, bus.a_i[22:0]};
            sigs1_d = {1'b1, bus.b_i[22:0]};
            d1_d    = a_exp_s - b_exp_s;
        end else begin
            sign1_d = bus.b_i[31];
            exp1_d  = b_exp_s;
            sigb1_d = {1'b1, bus.b_i[22:0]};
            sigs1_d = {1'b1, bus.a_i[22:0]};
            d1_d    = b_exp_s - a_exp_s;
        end
    end

    // Stage 2: align the smaller significand into 24+3 guard bits, no sticky
    always_comb begin
        v2_d    = v1_q;
        byp2_d  = byp1_q;
        bypv2_d = bypv1_q;
        sign2_d = sign1_q;
        sub2_d  = sub1_q;
        exp2_d  = exp1_q;
        sigb2_d = sigb1_q;
        if (d1_q >= 8'd27) begin
            small2_d = 27'd0;
        end else begin
            small2_d = {sigs1_q, 3'b000} >> d1_q;
        end
    end

    // Stage 3: magnitude add or subtract; big >= small so the difference is never negative
    always_comb begin
        v3_d    = v2_q;
        byp3_d  = byp2_q;
        bypv3_d = bypv2_q;
        sign3_d = sign2_q;
        exp3_d  = exp2_q;
        if (sub2_q) begin
            sum3_d = {1'b0, sigb2_q, 3'b000} - {1'b0, small2_q};
        end else begin
            sum3_d = {1'b0, sigb2_q, 3'b000} + {1'b0, small2_q};
        end
    end

    assign lzc_s     = lzc27(sum3_q[26:0]);
    assign norm_sh_s = sum3_q[26:0] << lzc_s;
    assign unused_s  = ^{norm_sh_s[26], norm_sh_s[2:0]};

    // Stage 4: normalize, truncate, and apply the result priority rules
    always_comb begin
        frac_s  = 23'd0;
        exp_n_s = 10'sd0;
        if (sum3_q[27]) begin
            frac_s  = sum3_q[26:4];
            exp_n_s = $signed({2'b00, exp3_q}) + 10'sd1;
        end else begin
            frac_s  = norm_sh_s[25:3];
            exp_n_s = $signed({2'b00, exp3_q}) - $signed({5'b00000, lzc_s});
        end
        if (byp3_q) begin
            res_s = bypv3_q;
        end else if (sum3_q == 28'd0) begin
            res_s = 32'h0000_0000;
        end else if (exp_n_s >= 10'sd255) begin
            res_s = {sign3_q, 8'hFF, 23'd0};
        end else if (exp_n_s <= 10'sd0) begin
            res_s = 32'h0000_0000;
        end else begin
            res_s = {sign3_q, exp_n_s[7:0], frac_s};
        end
        valid_d = v3_q;
        if (v3_q) begin
            sum_d = res_s;
        end else begin
            sum_d = sum_q;
        end
    end

    // Pipeline registers; reset discards every in-flight operation
    always_ff @(negedge clkn_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q <= 1'b0; byp1_q <= 1'b0; sign1_q <= 1'b0; sub1_q <= 1'b0;
            bypv1_q <= 32'd0; exp1_q <= 8'd0; d1_q <= 8'd0; sigb1_q <= 24'd0; sigs1_q <= 24'd0;
            v2_q <= 1'b0; byp2_q <= 1'b0; sign2_q <= 1'b0; sub2_q <= 1'b0;
            bypv2_q <= 32'd0; exp2_q <= 8'd0; sigb2_q <= 24'd0; small2_q <= 27'd0;
            v3_q <= 1'b0; byp3_q <= 1'b0; sign3_q <= 1'b0;
            bypv3_q <= 32'd0; exp3_q <= 8'd0; sum3_q <= 28'd0;
            valid_q <= 1'b0; sum_q <= 32'd0;
        end else begin
            v1_q <= v1_d; byp1_q <= byp1_d; sign1_q <= sign1_d; sub1_q <= sub1_d;
            bypv1_q <= bypv1_d; exp1_q <= exp1_d; d1_q <= d1_d; sigb1_q <= sigb1_d; sigs1_q <= sigs1_d;
            v2_q <= v2_d; byp2_q <= byp2_d; sign2_q <= sign2_d; sub2_q <= sub2_d;
            bypv2_q <= bypv2_d; exp2_q <= exp2_d; sigb2_q <= sigb2_d; small2_q <= small2_d;
            v3_q <= v3_d; byp3_q <= byp3_d; sign3_q <= sign3_d;
            bypv3_q <= bypv3_d; exp3_q <= exp3_d; sum3_q <= sum3_d;
            valid_q <= valid_d; sum_q <= sum_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.sum_o   = sum_q;

endmodule

// File: tb/tb_fp32_add_pipe.sv
// Scoreboard bench for fp32_add_pipe: directed cases plus randomized streaming
// checked against a truncating arithmetic reference model.
module tb_fp32_add_pipe;

    logic clkn_i = 1'b0;
    logic rst_i;
    fp32_add_pipe_if bus();

    fp32_add_pipe #(.LATENCY(4), .EXP_BIAS(127)) dut (
        .clkn_i (clkn_i),
        .rst_i  (rst_i),
        .bus    (bus)
    );

    always #5 clkn_i = ~clkn_i;

    typedef struct {
        int          c;
        logic [31:0] e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(negedge clkn_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Truncating reference: exact integer significand arithmetic with 3 guard bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, eg, d, msb, e;
        longint      ma, mb, big, sml, s, frac;
        logic        sg;
        logic [31:0] r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return 32'h7FC0_0000;
        if (ea == 0 && eb == 0) return 32'h0000_0000;
        if (ea == 0) return b;
        if (eb == 0) return a;
        ma = longint'(a[22:0]) + 64'sd8388608;
        mb = longint'(b[22:0]) + 64'sd8388608;
        if (a[30:0] >= b[30:0]) begin
            big = ma; sml = mb; eg = ea; d = ea - eb; sg = a[31];
        end else begin
            big = mb; sml = ma; eg = eb; d = eb - ea; sg = b[31];
        end
        big = big * 8;
        sml = (d >= 27) ? 64'sd0 : ((sml * 8) >>> d);
        s   = (a[31] != b[31]) ? (big - sml) : (big + sml);
        if (s == 0) return 32'h0000_0000;
        msb = 0;
        for (int i = 0; i < 40; i++) if (s[i]) msb = i;
        e = eg + (msb - 26);
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        if (e <= 0) return 32'h0000_0000;
        frac = (msb >= 23) ? (s >>> (msb - 23)) : (s <<< (23 - msb));
        r = {sg, e[7:0], frac[22:0]};
        return r;
    endfunction

    task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic use_const, input logic [31:0] req);
        exp_t it;
        @(negedge clkn_i);
        #1;
        bus.valid_i = v;
        bus.a_i     = a;
        bus.b_i     = b;
        if (v) begin
            it.c = cyc;
            it.e = use_const ? req : ref_add(a, b);
            sb.push_back(it);
        end
    endtask

    function automatic logic [31:0] rnd_norm(input int e);
        logic [31:0] r;
        int          ec;
        ec = (e < 1) ? 1 : ((e > 254) ? 254 : e);
        r  = {1'($urandom_range(0, 1)), 8'(ec), 23'($urandom)};
        return r;
    endfunction

    // Monitor: every presented result must match the oldest expectation, on time
    initial begin
        exp_t it;
        forever begin
            @(posedge clkn_i);
            if (bus.valid_o) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid actual=1 required=0 sum=%h (cycle %0d)", bus.sum_o, cyc);
                end else begin
                    it = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(it.c + 4));
                    chk("sum", bus.sum_o, it.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] da[9] = '{32'h3F80_0000, 32'h4040_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'h3F80_0000,
                           32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h0000_0001};
    logic [31:0] db[9] = '{32'h3F80_0000, 32'hBF80_0000, 32'hBFC0_0000, 32'hBF40_0000, 32'h3080_0000,
                           32'h3380_0000, 32'h7F7F_FFFF, 32'h1234_5678, 32'h3F80_0000};
    logic [31:0] de[9] = '{32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 32'h3E80_0000, 32'h3F80_0000,
                           32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h3F80_0000};

    initial begin
        logic [31:0] ra, rb;
        int          nvalid;
        int          ea;
        bit          v;
        rst_i       = 1'b1;
        bus.valid_i = 1'b0;
        bus.a_i     = 32'd0;
        bus.b_i     = 32'd0;
        repeat (3) @(negedge clkn_i);
        @(posedge clkn_i);
        chk("reset_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("reset_sum", bus.sum_o, 32'd0);
        @(negedge clkn_i);
        #1 rst_i = 1'b0;

        db[7] = $urandom;
        for (int i = 0; i < 9; i++) issue(1'b1, da[i], db[i], 1'b1, de[i]);
        for (int i = 0; i < 6; i++) issue(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Reset with three operations in flight: none of them may emerge
        for (int i = 0; i < 3; i++) issue(1'b1, rnd_norm(127), rnd_norm(127), 1'b0, 32'd0);
        @(negedge clkn_i);
        #1;
        rst_i = 1'b1;
        bus.valid_i = 1'b0;
        sb.delete();
        @(posedge clkn_i);
        chk("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("midrst_sum", bus.sum_o, 32'd0);
        @(negedge clkn_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 6; i++) issue(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        issue(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000);

        // Streaming with a toggling valid pattern
        nvalid = 0;
        for (int i = 0; nvalid < 20; i++) begin
            v  = ((i % 4) != 3) && ((i % 7) != 5);
            ea = int'($urandom_range(60, 190));
            ra = rnd_norm(ea);
            if ((i % 5) == 2) rb = {~ra[31], ra[30:23], ra[22:0] ^ 23'($urandom_range(0, 15))};
            else rb = rnd_norm(ea + int'($urandom_range(0, 40)) - 20);
            issue(v, ra, rb, 1'b0, 32'd0);
            if (v) nvalid++;
        end
        issue(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clkn_i);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clkn_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
